// File: rtl/npu_debug_pkg.sv
// npu_debug_pkg: shared widths and snapshot packing for the NPU debug serializer
package npu_debug_pkg;
    localparam int DEB_BYTE_W = 8;
    localparam int DEB_NUM_BYTES = 12;
    localparam int DEB_FRAME_W = DEB_BYTE_W * DEB_NUM_BYTES;
    function automatic logic [DEB_FRAME_W-1:0] pack_frame(
        input logic [15:0] ssfr,
        input logic [15:0] con_sig,
        input logic [15:0] mac2,
        input logic [15:0] mac1,
        input logic [7:0]  dd,
        input logic [7:0]  dc,
        input logic [7:0]  db,
        input logic [7:0]  da
    );
        return {ssfr, con_sig, mac2, mac1, dd, dc, db, da};
    endfunction
endpackage

// File: rtl/piso_deb_byte_shift_reg.sv
// byte_shift_reg: frame load/shift register emitting its top byte per shift into a registered output
module byte_shift_reg
    import npu_debug_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   shift,
    input  logic [DEB_FRAME_W-1:0] load_data,
    output logic [DEB_BYTE_W-1:0]  d_out
);
    logic [DEB_FRAME_W-1:0] sr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            d_out <= '0;
        end else if (clr) begin
            sr    <= '0;
            d_out <= '0;
        end else if (en && !shift) begin
            sr <= load_data;
        end else if (en) begin
            d_out <= sr[DEB_FRAME_W-1 -: DEB_BYTE_W];
            sr    <= {sr[DEB_FRAME_W-DEB_BYTE_W-1:0], {DEB_BYTE_W{1'b0}}};
        end
    end
endmodule

// File: rtl/piso_deb.sv
// piso_deb: debug snapshot serializer, loads a 96-bit frame and streams it MSB byte first
module piso_deb
    import npu_debug_pkg::*;
(
    input  logic                  CLKEXT,
    input  logic                  RST_GLO,
    input  logic                  EN_PISO_DEB,
    input  logic                  CLR_PISO_DEB,
    input  logic                  SHIFT_DEB,
    input  logic [15:0]           SSFR,
    input  logic [15:0]           CON_SIG,
    input  logic [15:0]           MAC2,
    input  logic [15:0]           MAC1,
    input  logic [7:0]            DD,
    input  logic [7:0]            DC,
    input  logic [7:0]            DB,
    input  logic [7:0]            DA,
    output logic [DEB_BYTE_W-1:0] D_OUT
);
    byte_shift_reg u_sr (
        .clk      (CLKEXT),
        .rst      (RST_GLO),
        .clr      (CLR_PISO_DEB),
        .en       (EN_PISO_DEB),
        .shift    (SHIFT_DEB),
        .load_data(pack_frame(SSFR, CON_SIG, MAC2, MAC1, DD, DC, DB, DA)),
        .d_out    (D_OUT)
    );
endmodule

// File: tb/tb_piso_deb.sv
// tb_piso_deb: directed-vector bench for the debug byte serializer
module tb_piso_deb;
    logic        CLKEXT = 1'b0;
    logic        RST_GLO = 1'b1;
    logic        EN_PISO_DEB = 1'b0;
    logic        CLR_PISO_DEB = 1'b0;
    logic        SHIFT_DEB = 1'b0;
    logic [15:0] SSFR = '0, CON_SIG = '0, MAC2 = '0, MAC1 = '0;
    logic [7:0]  DD = '0, DC = '0, DB = '0, DA = '0;
    logic [7:0]  D_OUT;
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] f2 [12] = '{8'hAA, 8'hAA, 8'h55, 8'h55, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] f3 [12] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

    piso_deb dut (
        .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .EN_PISO_DEB(EN_PISO_DEB),
        .CLR_PISO_DEB(CLR_PISO_DEB), .SHIFT_DEB(SHIFT_DEB),
        .SSFR(SSFR), .CON_SIG(CON_SIG), .MAC2(MAC2), .MAC1(MAC1),
        .DD(DD), .DC(DC), .DB(DB), .DA(DA), .D_OUT(D_OUT)
    );

    always #5 CLKEXT = ~CLKEXT;

    task automatic chk(input logic [7:0] exp, input string tag);
        n_vec++;
        assert (D_OUT === exp) else begin
            n_bad++;
            $error("FAIL %s: D_OUT=%h expected %h", tag, D_OUT, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic sh);
        @(negedge CLKEXT);
        EN_PISO_DEB = en;
        CLR_PISO_DEB = clr;
        SHIFT_DEB = sh;
        @(posedge CLKEXT);
        #1;
    endtask

    task automatic set2();
        SSFR = 16'hAAAA; CON_SIG = 16'h5555; MAC2 = 16'h1234; MAC1 = 16'hABCD;
        DD = 8'h01; DC = 8'h02; DB = 8'h03; DA = 8'h04;
    endtask

    task automatic set3();
        SSFR = 16'hFFFF; CON_SIG = 16'h0000; MAC2 = 16'hDEAD; MAC1 = 16'hBEEF;
        DD = 8'hAA; DC = 8'hBB; DB = 8'hCC; DA = 8'hDD;
    endtask

    initial begin
        #2 chk(8'h00, "reset");
        @(negedge CLKEXT) RST_GLO = 1'b0;
        set2();
        step(0, 0, 1); chk(8'h00, "idle_shift");
        step(0, 0, 0); chk(8'h00, "idle_load");
        step(1, 0, 0); chk(8'h00, "t2_load");
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1); chk(f2[i], $sformatf("t2_byte%0d", i));
        end
        set3();
        step(1, 0, 0); chk(8'h04, "t3_load_hold");
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1); chk(f3[i], $sformatf("t3_byte%0d", i));
        end
        step(1, 0, 1); chk(8'h00, "t3_overshift");
        set2();
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1); chk(f2[i], $sformatf("t4_pre%0d", i));
        end
        step(0, 0, 1); chk(8'h55, "t4_hold1");
        step(0, 0, 1); chk(8'h55, "t4_hold2");
        for (int i = 3; i < 12; i++) begin
            step(1, 0, 1); chk(f2[i], $sformatf("t4_byte%0d", i));
        end
        step(1, 0, 0);
        step(1, 0, 1); chk(8'hAA, "t5_first");
        step(1, 1, 1); chk(8'h00, "t5_clr");
        step(1, 0, 1); chk(8'h00, "t5_after_clr1");
        step(1, 0, 1); chk(8'h00, "t5_after_clr2");
        step(1, 0, 0);
        step(1, 0, 1); chk(8'hAA, "t5_reload");
        @(negedge CLKEXT) RST_GLO = 1'b1;
        #1 chk(8'h00, "t5_async_rst");
        RST_GLO = 1'b0;
        step(1, 0, 1); chk(8'h00, "t5_rst_cleared_sr");
        set3();
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1); chk(f3[i], $sformatf("t6_pre%0d", i));
        end
        set2();
        step(1, 0, 0); chk(8'hDE, "t6_load_hold");
        set3();
        step(1, 0, 1); chk(8'hAA, "t6_new0");
        step(1, 0, 1); chk(8'hAA, "t6_new1");
        step(1, 0, 1); chk(8'h55, "t6_new2");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
